// File: rtl/mac_pkg.sv
// mac_pkg
// Shared constants and the round-robin search helper for the MAC arbiter
// slice. OP_W is the operand width, RES_W the result width and MAX_REQ the
// largest requester count that the arbiter supports.
package mac_pkg;

  localparam int OP_W    = 16;
  localparam int RES_W   = 32;
  localparam int MAX_REQ = 4;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_result_t;

  // This function returns the first set bit of valid at or above ptr,
  // wrapping at nreq. Bits at or above nreq are never considered.
  function automatic rr_result_t rr_next(input logic [MAX_REQ-1:0] valid,
                                         input logic [1:0]         ptr,
                                         input int                 nreq);
    rr_result_t res;
    int         cand;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      cand = (int'(ptr) + k) % nreq;
      if (k < nreq && !res.found && valid[cand[1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick among NREQ requesters.
// Ports:
//   valid  - per-requester request valid
//   ptr    - index with highest priority this cycle
//   enable - when low no grant is issued
//   grant  - one-hot grant, or zero
//   idx    - index of the granted requester
//   found  - a grant is issued this cycle
module rr_arbiter
  import mac_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [1:0]         ptr_ext;
  rr_result_t         pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    ptr_ext               = 2'(ptr);
    pick                  = rr_next(valid_ext, ptr_ext, NREQ);
    found                 = enable & pick.found;
    idx                   = IDW'(pick.idx);
    grant                 = '0;
    if (found) grant[pick.idx] = 1'b1;
  end

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter
// Shares one external combinational MAC (R = A*B + C) between NREQ
// requesters. The winning operands are registered in S1 and drive the MAC.
// The MAC result is registered in S2 and returned with the requester id
// under valid/ready back-pressure.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake
//   req_a/req_b/req_c     - packed per-requester operands (16 bits each)
//   mac_a/mac_b/mac_c     - operands to the external MAC (zero when idle)
//   mac_r                 - MAC result
//   res_valid/res_ready   - result handshake
//   res_data/res_id       - registered result and originating requester
//   busy                  - either pipeline stage is occupied
module mac_arbiter
  import mac_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OP_W*NREQ-1:0] req_a,
  input  logic [OP_W*NREQ-1:0] req_b,
  input  logic [OP_W*NREQ-1:0] req_c,
  output logic [OP_W-1:0]      mac_a,
  output logic [OP_W-1:0]      mac_b,
  output logic [OP_W-1:0]      mac_c,
  input  logic [RES_W-1:0]     mac_r,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_W-1:0]     res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 busy
);

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_a_q, s1_a_d;
  logic [OP_W-1:0]  s1_b_q, s1_b_d;
  logic [OP_W-1:0]  s1_c_q, s1_c_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic             s2_valid_q, s2_valid_d;
  logic [RES_W-1:0] s2_data_q, s2_data_d;
  logic [IDW-1:0]   s2_id_q, s2_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             s2_free;
  logic             s1_free;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_found;

  // A stage is free when empty or when its contents leave this cycle, so a
  // drain, an S1->S2 move and a new grant can all happen together.
  assign s2_free = !s2_valid_q || res_ready;
  assign s1_free = !s1_valid_q || s2_free;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .valid  (req_valid),
    .ptr    (ptr_q),
    .enable (s1_free),
    .grant  (grant),
    .idx    (gnt_idx),
    .found  (gnt_found)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    ptr_d      = ptr_q;

    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = mac_r;
        s2_id_d   = s1_id_q;
      end
    end

    if (s1_free) begin
      s1_valid_d = gnt_found;
      if (gnt_found) begin
        s1_a_d  = req_a[OP_W*int'(gnt_idx) +: OP_W];
        s1_b_d  = req_b[OP_W*int'(gnt_idx) +: OP_W];
        s1_c_d  = req_c[OP_W*int'(gnt_idx) +: OP_W];
        s1_id_d = gnt_idx;
        ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      ptr_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
    end
  end

  // The MAC inputs are gated so that an idle MAC sees zeros, not stale operands.
  assign mac_a     = s1_valid_q ? s1_a_q : '0;
  assign mac_b     = s1_valid_q ? s1_b_q : '0;
  assign mac_c     = s1_valid_q ? s1_c_q : '0;
  assign req_ready = grant;
  assign res_valid = s2_valid_q;
  assign res_data  = s2_data_q;
  assign res_id    = s2_id_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter
// Bench for mac_arbiter with three requesters and an exact MAC model.
// The reference model tracks only the in-flight count and a rotating
// priority pointer. Expected results are queued at grant time and popped
// by an independent monitor on each result handshake.
module tb_mac_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 2;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [47:0] req_a, req_b, req_c;
  logic [15:0] mac_a, mac_b, mac_c;
  logic [31:0] mac_r;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  int   m_n     = 0;
  bit   m_glast = 1'b0;
  int   m_ptr   = 0;
  int   m_grant = -1;

  always #5 clk = ~clk;

  assign mac_r = 32'(mac_a) * 32'(mac_b) + 32'(mac_c);

  mac_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_r     (mac_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The monitor pops one expectation per accepted result, apart from the stimulus.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL scoreboard_empty actual=id%0d/%0h required=no_result", res_id, res_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", res_data, e.data);
        check("res_id", 32'(res_id), 32'(e.id));
      end
    end
  end

  // The model holds at most two items. The oldest item is visible unless the
  // only item was granted on the previous edge. Grants stop only when two
  // items are held and the result is not taken.
  task automatic checkOutput(input logic [2:0] v, input logic [47:0] a, input logic [47:0] b,
                             input logic [47:0] c, input logic rr);
    bit         presented, allowed, drain;
    int         gi;
    logic [2:0] exp_ready;
    exp_t       e;
    presented = (m_n == 2) || (m_n == 1 && !m_glast);
    allowed   = !(m_n == 2 && !rr);
    gi        = -1;
    if (allowed) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (v[i] && gi < 0) gi = i;
      end
    end
    exp_ready = '0;
    if (gi >= 0) exp_ready[gi] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(presented));
    check("busy", 32'(busy), 32'(m_n > 0));
    drain = presented && rr;
    if (gi >= 0) begin
      e.data = 32'(a[16*gi +: 16]) * 32'(b[16*gi +: 16]) + 32'(c[16*gi +: 16]);
      e.id   = 2'(gi);
      exp_q.push_back(e);
      m_ptr = (gi + 1) % NREQ;
    end
    m_n     = m_n + ((gi >= 0) ? 1 : 0) - (drain ? 1 : 0);
    m_glast = (gi >= 0);
    m_grant = gi;
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [47:0] a, input logic [47:0] b,
                               input logic [47:0] c, input logic rr);
    @(posedge clk);
    #1;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_c     = c;
    res_ready = rr;
    @(negedge clk);
    checkOutput(v, a, b, c, rr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(3'b000, '0, '0, '0, 1'b1);
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_res_id"}, 32'(res_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mac_a"}, 32'(mac_a), 32'd0);
    check({tag, "_mac_b"}, 32'(mac_b), 32'd0);
    check({tag, "_mac_c"}, 32'(mac_c), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_n     = 0;
    m_glast = 1'b0;
    m_ptr   = 0;
    exp_q.delete();
    @(negedge clk);
    checkResetState("mid_reset");
  endtask

  logic [2:0]  pend;
  logic [47:0] ra, rb, rc;
  logic [31:0] held;
  int          grants;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    $display("[TB] single request");
    applyStimulus(3'b001, 48'd3, 48'd4, 48'd5, 1'b1);
    idle(3);

    $display("[TB] contention");
    for (int i = 0; i < 8; i++)
      applyStimulus(3'b011, {16'd0, 16'd9, 16'd7}, {16'd0, 16'd10, 16'd6}, {16'd0, 16'd11, 16'd2}, 1'b1);
    idle(3);

    $display("[TB] back-pressure");
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b011, {16'd0, 16'd21, 16'd13}, {16'd0, 16'd3, 16'd100}, {16'd0, 16'd1, 16'd7}, 1'b0);
      if (req_ready != 3'b000) grants++;
      if (i == 2) held = res_data;
      if (i > 2) check("stall_data_stable", res_data, held);
    end
    check("stall_grants", 32'(grants), 32'd2);
    idle(4);

    $display("[TB] wrap");
    applyStimulus(3'b100, {16'd5, 16'd0, 16'd0}, {16'd6, 16'd0, 16'd0}, {16'd7, 16'd0, 16'd0}, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(3'b111, {16'd30, 16'd20, 16'd10}, {16'd3, 16'd2, 16'd1}, {16'd300, 16'd200, 16'd100}, 1'b1);
    applyStimulus(3'b001, 48'd8, 48'd8, 48'd8, 1'b1);
    idle(3);

    // All-ones operands give 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000 exactly.
    $display("[TB] max operands");
    applyStimulus(3'b001, 48'hFFFF, 48'hFFFF, 48'hFFFF, 1'b1);
    idle(3);

    $display("[TB] reset mid-flight");
    applyStimulus(3'b011, {16'd0, 16'd4, 16'd2}, {16'd0, 16'd4, 16'd2}, {16'd0, 16'd4, 16'd2}, 1'b0);
    applyStimulus(3'b011, {16'd0, 16'd4, 16'd2}, {16'd0, 16'd4, 16'd2}, {16'd0, 16'd4, 16'd2}, 1'b0);
    doReset();
    applyStimulus(3'b110, {16'd1, 16'd2, 16'd0}, {16'd3, 16'd4, 16'd0}, {16'd5, 16'd6, 16'd0}, 1'b1);
    idle(3);

    // Each pending request keeps its valid and operands until it is granted.
    $display("[TB] random");
    pend = '0;
    ra   = '0;
    rb   = '0;
    rc   = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]        = 1'b1;
          ra[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
          rb[16*i +: 16] = 16'($urandom);
          rc[16*i +: 16] = 16'($urandom);
        end
      end
      applyStimulus(pend, ra, rb, rc, $urandom_range(0, 3) != 0);
      if (m_grant >= 0) pend[m_grant] = 1'b0;
    end
    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
